// File: rtl/lcd_pkg.sv
// Shared types, init command ROM and opcode helpers for the HD44780 command sequencer.
package lcd_pkg;

   typedef enum logic [2:0] {
      INIT_WAIT,
      INIT_ISSUE,
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      EXEC,
      DONE
   } lcd_state_e;

   typedef struct packed {
      logic       rs;
      logic [7:0] db;
   } lcd_req_t;

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   localparam int INIT_LEN = 4;
   // Function set 8-bit/2-line, display on, clear, entry mode increment.
   localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

   // Clear and return-home (bit 0 of home is don't-care) need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
      return !rs && ((db == LCD_CMD_CLEAR) || (db[7:1] == LCD_CMD_HOME[7:1]));
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter shared by every timed state; saturates at zero.
module lcd_delay_counter #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= RST_VAL;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Sequences HD44780 command/data writes for a custom-instruction port, pulsing done when the panel is ready.
// Define LCD_INIT_SEQ_EN to run the power-on wait and init command sequence after reset.
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC   = 2,
   parameter int PULSE_CYC   = 25,
   parameter int HOLD_CYC    = 2,
   parameter int EXEC_CYC    = 2000,
   parameter int LONG_CYC    = 82000,
   parameter int POWERUP_CYC = 750000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        done,
   output logic [31:0] result,
   output logic        rw,
   output logic        en,
   output logic        rs,
   output logic [7:0]  db
);

   localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC), max_int(HOLD_CYC, EXEC_CYC)),
                                    max_int(LONG_CYC, POWERUP_CYC));
   localparam int CW = $clog2(MAX_CYC) + 1;

`ifdef LCD_INIT_SEQ_EN
   localparam lcd_state_e      RST_STATE = INIT_WAIT;
   localparam logic [CW-1:0]   CNT_RST   = CW'(POWERUP_CYC - 1);
`else
   localparam lcd_state_e      RST_STATE = IDLE;
   localparam logic [CW-1:0]   CNT_RST   = '0;
`endif

   lcd_state_e    state, state_n;
   lcd_req_t      cur, pend;
   logic          pend_vld;
   logic          cur_is_req;
   logic          cnt_load, cnt_zero;
   logic [CW-1:0] cnt_val;
   logic          init_left;
   logic [7:0]    init_byte;
   logic          unused_bits;

   assign unused_bits = ^{dataa[31:1], datab[31:8]};

   lcd_delay_counter #(
      .W       (CW),
      .RST_VAL (CNT_RST)
   ) u_delay (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

`ifdef LCD_INIT_SEQ_EN
   logic [2:0] init_idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         init_idx <= '0;
      else if (state == INIT_ISSUE)
         init_idx <= init_idx + 3'd1;
   end

   assign init_left = (init_idx != 3'(INIT_LEN));
   assign init_byte = INIT_ROM[init_idx[1:0]];
`else
   assign init_left = 1'b0;
   assign init_byte = 8'h00;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= RST_STATE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         INIT_WAIT:  if (cnt_zero) state_n = INIT_ISSUE;
         INIT_ISSUE: state_n = SETUP;
         IDLE:       if (pend_vld || start) state_n = SETUP;
         SETUP:      if (cnt_zero) state_n = PULSE;
         PULSE:      if (cnt_zero) state_n = HOLD;
         HOLD:       if (cnt_zero) state_n = EXEC;
         EXEC:       if (cnt_zero) state_n = DONE;
         DONE:       state_n = init_left ? INIT_ISSUE : IDLE;
         default:    state_n = RST_STATE;
      endcase
   end

   // Every timed state is entered from a different state, so a transition is the load strobe.
   always_comb begin
      cnt_load = (state_n != state);
      cnt_val  = '0;
      case (state_n)
         SETUP:     cnt_val = CW'(SETUP_CYC - 1);
         PULSE:     cnt_val = CW'(PULSE_CYC - 1);
         HOLD:      cnt_val = CW'(HOLD_CYC - 1);
         EXEC:      cnt_val = is_long_cmd(cur.rs, cur.db) ? CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
         INIT_WAIT: cnt_val = CW'(POWERUP_CYC - 1);
         default:   cnt_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur        <= '0;
         cur_is_req <= 1'b0;
         pend       <= '0;
         pend_vld   <= 1'b0;
         en         <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
      end else begin
         en   <= (state_n == PULSE);
         done <= (state_n == DONE) && cur_is_req;
         if ((state_n == DONE) && cur_is_req)
            result <= {23'b0, cur.rs, cur.db};

         if (state == INIT_ISSUE) begin
            cur.rs     <= 1'b0;
            cur.db     <= init_byte;
            cur_is_req <= 1'b0;
         end else if ((state == IDLE) && (state_n == SETUP)) begin
            cur_is_req <= 1'b1;
            if (pend_vld)
               cur <= pend;
            else begin
               cur.rs <= dataa[0];
               cur.db <= datab[7:0];
            end
         end

         // One-deep catch for a request that lands while busy; a second one is dropped.
         if (state == IDLE)
            pend_vld <= 1'b0;
         else if (start && !pend_vld) begin
            pend_vld <= 1'b1;
            pend.rs  <= dataa[0];
            pend.db  <= datab[7:0];
         end
      end
   end

   assign rw = 1'b0;
   assign rs = cur.rs;
   assign db = cur.db;

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Multicycle custom-instruction controller that sequences all accesses to the HD44780-compatible character LCD on the board. Accepts one command or data byte per processor request, drives `rs`/`rw`/`en`/`db` with the setup, enable-pulse, hold and execution delays the panel requires, and signals `done` only after the panel can accept the next byte. Sits between the soft-core custom-instruction port and the LCD pins. Software therefore never busy-waits or polls.

## Interface
- `SETUP_CYC`, default 2: cycles `rs`/`db` are stable before `en` rises (≥40 ns at 50 MHz).
- `PULSE_CYC`, default 25: cycles `en` is held high (≥450 ns).
- `HOLD_CYC`, default 2: cycles `rs`/`db` are held after `en` falls.
- `EXEC_CYC`, default 2000: post-write wait for normal instructions and data (40 µs).
- `LONG_CYC`, default 82000: post-write wait for clear/home (1.64 ms).
- `POWERUP_CYC`, default 750000: power-on wait before the init sequence (15 ms). Used only with the init feature.
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request strobe from the custom-instruction port.
- `dataa`, in, 32: bit 0 selects the register: 0 = command, 1 = data. Other bits are ignored.
- `datab`, in, 32: bits 7:0 are the byte to write. Other bits are ignored.
- `done`, out, 1: one-cycle completion pulse.
- `result`, out, 32: `{23'b0, rs, db}` of the completed write, valid while `done` is high.
- `rw`, out, 1: constant 0, because the block never reads the panel.
- `en`, out, 1: LCD enable.
- `rs`, out, 1: LCD register select.
- `db`, out, 8: LCD data bus.

## Operation
- States: INIT_WAIT, INIT_ISSUE, IDLE, SETUP, PULSE, HOLD, EXEC, DONE.
- In IDLE, `start` latches `rs`←`dataa[0]` and `db`←`datab[7:0]`, then goes to SETUP.
- SETUP lasts SETUP_CYC cycles, then goes to PULSE. `en`=1 for all PULSE_CYC cycles of PULSE.
- HOLD lasts HOLD_CYC cycles with `en`=0, then goes to EXEC.
- Long delay applies when `rs`=0 and (`db`==8'h01 or `db[7:1]`==7'b0000001). EXEC then waits LONG_CYC cycles; otherwise it waits EXEC_CYC.
- DONE lasts one cycle and asserts `done`. It returns to IDLE, or to INIT_ISSUE while the init sequence is incomplete.
- A single down-counter serves every timed state. Its width is `$clog2` of the largest parameter plus 1. It is loaded on state entry with N−1.
- A `start` that arrives outside IDLE is latched into a one-deep pending register (valid, rs, byte). That request is served on the next entry to IDLE, with no extra idle cycle. A second `start` while pending is valid is dropped. The processor stalls on `done`, so this is a protocol violation and needs no further handling.
- `done` fires only for processor requests, never for init writes.
- Asserting `reset_n` mid-transfer aborts the transfer: `en` drops immediately and the pending request is lost.

## Timing
- Reset values: `en`=0, `rs`=0, `db`=8'h00, `done`=0, `result`=0, state IDLE (INIT_WAIT with the init feature), pending cleared.
- `en` rises SETUP_CYC cycles after the `start` edge and is high for exactly PULSE_CYC cycles.
- Latency from `start` to `done` is 1+SETUP_CYC+PULSE_CYC+HOLD_CYC+(EXEC_CYC or LONG_CYC) cycles. With defaults this is 2030 cycles for normal writes and 82030 for long writes.
- `rs`/`db` change only on IDLE→SETUP. They hold their last value while idle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `LCD_INIT_SEQ_EN` defined: after reset, wait POWERUP_CYC cycles in INIT_WAIT, then write the commands 8'h38, 8'h0C, 8'h01, 8'h06 through SETUP…EXEC. 8'h01 gets the long delay. Then enter IDLE.
- `LCD_INIT_SEQ_EN` undefined: reset goes straight to IDLE, and software initializes the panel.

## Structure
- Shared package `lcd_pkg`:
  - state enum;
  - init command ROM constant (4×8 bits);
  - opcode constants `LCD_CMD_CLEAR`=8'h01 and `LCD_CMD_HOME`=8'h02;
  - helper function `is_long_cmd(rs, db)`.
- Natural sub-module: `lcd_delay_counter`, a loadable down-counter with a `zero` flag. The init-step index stays in the top level.

## Test plan
Benches use small parameters: SETUP=2, PULSE=4, HOLD=2, EXEC=10, LONG=30, POWERUP=20.
- Reset, then `start` with `dataa`=1 and `datab`=8'h41 → `rs`=1, `db`=8'h41; `en` is high cycles 3–6 after `start`; `done` pulses at cycle 19 with `result`=32'h141.
- `start` with `dataa`=0 and `datab`=8'h01 → `done` at cycle 39 (long delay). `datab`=8'h03 → also long. `datab`=8'h38 → normal, cycle 19.
- `start` asserted during EXEC of a prior write → second write begins immediately after the first `done`, with two `done` pulses total.
- `reset_n` low during PULSE → `en`=0 asynchronously; after release, no `done` and outputs at reset values.
- `LCD_INIT_SEQ_EN` defined → after 20 cycles, four `en` pulses with `db` = 38, 0C, 01, 06 and `rs`=0, with no `done`. A `start` issued at cycle 5 is served after 8'h06.
- `rw` is 0 throughout all scenarios.
